// File: rtl/prau_quire_ctrl_if.sv
// prau_quire_ctrl_if: operator encoding and core-side request/response bus of the quire sequencer.
package prau_quire_pkg;
  typedef enum logic [3:0] {
    QCLR   = 4'd0,
    QNEG   = 4'd1,
    QMADD  = 4'd2,
    QMSUB  = 4'd3,
    QROUND = 4'd4,
    PADD   = 4'd5,
    PMUL   = 4'd6,
    PDIV   = 4'd7
  } prau_op_e;
endpackage

interface prau_quire_ctrl_if import prau_quire_pkg::*; #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) ();
  logic            in_valid_i;
  logic            in_ready_o;
  prau_op_e        operator_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic [TAGW-1:0] tag_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic [TAGW-1:0] tag_o;
  modport slave (
    input  in_valid_i, operator_i, operand_a_i, operand_b_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o
  );
  modport master (
    output in_valid_i, operator_i, operand_a_i, operand_b_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o
  );
endinterface

// File: rtl/prau_quire_ctrl.sv
// prau_quire_ctrl: issues one quire op at a time, holds it for the pipeline latency, returns the result.
module prau_quire_ctrl import prau_quire_pkg::*; #(
  parameter int XLEN          = 64,
  parameter int TAGW          = 5,
  parameter int MAC_LATENCY   = 4,
  parameter int ROUND_LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  prau_quire_ctrl_if.slave     core,
  output logic                 busy_o,
  output prau_op_e             q_operator_o,
  output logic [XLEN-1:0]      q_operand_a_o,
  output logic [XLEN-1:0]      q_operand_b_o,
  output logic                 q_input_hs_o,
  output logic                 q_out_valid_o,
  input  logic [XLEN-1:0]      q_result_i
);
  localparam int MAXL = MAC_LATENCY > ROUND_LATENCY ? MAC_LATENCY : ROUND_LATENCY;
  localparam int CW = $clog2(MAXL + 1);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lat;
  prau_op_e op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic hs_q, hs_d, nq_q, nq_d, acc, last, quire_op, in_ready;
  always_comb begin
    quire_op = core.operator_i inside {QCLR, QNEG, QMADD, QMSUB, QROUND};
    lat      = (core.operator_i == QMADD || core.operator_i == QMSUB) ? CW'(MAC_LATENCY) :
               core.operator_i == QROUND ? CW'(ROUND_LATENCY) : CW'(1);
    in_ready = state_q == IDLE || (state_q == DONE && core.out_ready_i);
    acc      = core.in_valid_i && in_ready;
    last     = state_q == BUSY && cnt_q == '0;
    state_d  = acc ? BUSY : last ? DONE : (state_q == DONE && core.out_ready_i) ? IDLE : state_q;
    cnt_d    = acc ? lat - CW'(1) : (state_q == BUSY && !last) ? cnt_q - CW'(1) : cnt_q;
    // non-quire ops masquerade as QROUND so the quire only ever sees a read
    op_d     = acc ? (quire_op ? core.operator_i : QROUND) : op_q;
    a_d      = acc ? core.operand_a_i : a_q;
    b_d      = acc ? core.operand_b_i : b_q;
    tag_d    = acc ? core.tag_i : tag_q;
    nq_d     = acc ? !quire_op : nq_q;
    hs_d     = acc && quire_op;
    res_d    = last ? ((op_q == QROUND && !nq_q) ? q_result_i : '0) : res_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= QCLR;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      hs_q    <= 1'b0;
      nq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      hs_q    <= hs_d;
      nq_q    <= nq_d;
    end
  end
  assign core.in_ready_o  = in_ready;
  assign core.out_valid_o = state_q == DONE;
  assign core.result_o    = res_q;
  assign core.tag_o       = tag_q;
  assign busy_o           = state_q != IDLE;
  assign q_operator_o     = op_q;
  assign q_operand_a_o    = a_q;
  assign q_operand_b_o    = b_q;
  assign q_input_hs_o     = hs_q;
  assign q_out_valid_o    = last && (op_q == QMADD || op_q == QMSUB);
  a_hs_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni) q_input_hs_o |=> !q_input_hs_o);
  a_ov_mac: assert property (@(posedge clk_i) disable iff (!rst_ni)
    q_out_valid_o |-> (q_operator_o == QMADD || q_operator_o == QMSUB));
  a_resp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    core.out_valid_o && !core.out_ready_i |=> core.out_valid_o && $stable(core.result_o) && $stable(core.tag_o));
endmodule

// File: doc/prau_quire_ctrl.md
Name: prau_quire_ctrl

Overview:
- Issue/handshake sequencer directly upstream of the quire datapath (prau_quire) in the PRAU.
- Accepts quire operations from the core over a valid/ready interface and registers the operator, operands and tag.
- Holds them stable to the quire for the full MAC or round pipeline latency, and generates the input_hs / out_valid strobes the quire consumes.
- Captures the quire result and returns it to the core over a valid/ready response interface.

Parameters:
- XLEN, 64, operand/result width.
- TAGW, 5, width of the transaction tag (destination register id).
- MAC_LATENCY, 4, PositMAC pipeline depth in cycles; must be >=1.
- ROUND_LATENCY, 2, Quire2Posit pipeline depth in cycles; must be >=1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request ready.
- operator_i  in  prau_op_e  requested operation.
- operand_a_i  in  XLEN  posit operand A.
- operand_b_i  in  XLEN  posit operand B.
- tag_i  in  TAGW  request tag.
- out_valid_o  out  1  response valid.
- out_ready_i  in  1  response ready.
- result_o  out  XLEN  response data.
- tag_o  out  TAGW  response tag.
- busy_o  out  1  operation in flight (state != IDLE).
- q_operator_o  out  prau_op_e  operator to quire.
- q_operand_a_o  out  XLEN  operand A to quire.
- q_operand_b_o  out  XLEN  operand B to quire.
- q_input_hs_o  out  1  input handshake strobe to quire.
- q_out_valid_o  out  1  MAC-complete strobe to quire.
- q_result_i  in  XLEN  quire result_o.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset values:
  - state IDLE; in_ready_o=1; out_valid_o=0; result_o=0; tag_o=0; busy_o=0.
  - q_operator_o=QCLR; q_operand_a_o=0; q_operand_b_o=0; q_input_hs_o=0; q_out_valid_o=0.
- Issue:
  - in_ready_o = (state==IDLE) | (state==DONE & out_ready_i).
  - Accept at cycle T when in_valid_i & in_ready_o: register operator, operands and tag into the q_* / tag registers, and load the counter with LAT-1.
  - LAT = MAC_LATENCY for QMADD/QMSUB, ROUND_LATENCY for QROUND, 1 for QCLR/QNEG.
- BUSY occupies cycles T+1..T+LAT:
  - q_operator_o, q_operand_a_o and q_operand_b_o are held constant.
  - q_input_hs_o=1 only in cycle T+1.
  - In the last BUSY cycle (counter==0), q_out_valid_o=1 for QMADD/QMSUB only, and q_result_i is sampled into result_o.
  - Counter decrements each BUSY cycle.
- DONE begins at T+LAT+1:
  - out_valid_o=1; result_o and tag_o held stable until out_ready_i.
  - result_o = q_result_i for QROUND, 0 for all other ops.
- Response handshake:
  - out_valid_o & out_ready_i with no new accept -> IDLE.
  - With a simultaneous accept -> BUSY, zero bubble.
- After completion, q_operator_o keeps the last operator; q_input_hs_o and q_out_valid_o are 0.
  - Quire state is therefore stable: QCLR held is idempotent, QNEG/QMADD/QMSUB are strobe-gated, QROUND is read-only.
- Non-quire operator accepted: treated as LAT=1 with no strobes and result 0.
  - q_operator_o is loaded with QROUND so the quire is untouched.
- Exactly one operation is in flight; no request is accepted during BUSY.
- Counter width: $clog2(max(MAC_LATENCY,ROUND_LATENCY)+1).
- in_valid_i deasserted or operands changing during BUSY/DONE: ignored.
- Reset mid-operation (asynchronous): all registers return to reset values immediately, and the in-flight op produces no response.
  - Because quire_q shares rst_ni, it is cleared concurrently.
- Assertions:
  - q_input_hs_o is never high on two consecutive cycles.
  - q_out_valid_o only with q_operator_o in {QMADD,QMSUB}.
  - out_valid_o stays high and result_o/tag_o stay stable until out_ready_i.

Test Plan (posit32 values; quire instance attached):
- QCLR, then QMADD(0x40000000,0x40000000), then QROUND, with out_ready_i=1 -> QROUND result 0x40000000; QMADD out_valid_o asserted exactly 5 cycles after accept (MAC_LATENCY+1).
- After the previous case, QMSUB(0x40000000,0x40000000) then QROUND -> result 0x00000000; q_out_valid_o a single-cycle pulse in cycle T+4.
- QCLR, QMADD(0x40000000,0x48000000), QNEG, QROUND -> result 0xB8000000 (-2.0); QNEG q_input_hs_o is a one-cycle pulse.
- QROUND with out_ready_i=0 for 10 cycles -> out_valid_o, result_o and tag_o stable, in_ready_o=0 throughout; a new request presented on the release cycle is accepted the same cycle.
- Back-to-back requests, tags 3,4,5, out_ready_i tied 1 -> responses in order with tags 3,4,5; no idle cycle between accept and the preceding response.
- rst_ni asserted at T+2 of a QMADD -> out_valid_o never rises; after release, QROUND returns 0x00000000 and busy_o=0 in the first cycle out of reset.
